// File: rtl/parking_gate_controller.sv
// parking_gate_controller
// Arbitrates the single shared barrier gate between the entry and exit lanes
// and keeps the authoritative occupancy count. The lane sensors are treated as
// ground truth, so the count follows car_enter/car_exit in every state. All
// outputs apart from full/empty are registered, which means they report the
// state that was current one cycle earlier.
module parking_gate_controller #(
    parameter int CAPACITY    = 15,
    parameter int CNT_W       = 4,
    parameter int OPEN_CYCLES = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             entry_req,
    input  logic             exit_req,
    input  logic             car_enter,
    input  logic             car_exit,
    output logic             gate_open,
    output logic             grant_entry,
    output logic             grant_exit,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty,
    output logic             deny,
    output logic             timeout
);

    localparam int TMR_W = $clog2(OPEN_CYCLES + 1);
    localparam logic [CNT_W-1:0] CAP_VAL  = CNT_W'(CAPACITY);
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(OPEN_CYCLES);
    localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        OPEN_IN  = 2'd1,
        OPEN_OUT = 2'd2,
        CLOSE    = 2'd3
    } state_t;

    state_t           state_reg, state_next;
    logic [TMR_W-1:0] timer_reg, timer_next;
    logic             prefer_entry_reg, prefer_entry_next;
    // Remembers that the current CLOSE was reached by expiry rather than a car,
    // so the timeout pulse lands in the first closed output cycle.
    logic             timed_out_reg, timed_out_next;
    logic [CNT_W-1:0] count_reg, count_next;

    logic gate_open_reg, gate_open_next;
    logic grant_entry_reg, grant_entry_next;
    logic grant_exit_reg, grant_exit_next;
    logic deny_reg, deny_next;
    logic timeout_reg, timeout_next;

    logic full_w;
    logic empty_w;
    logic entry_ok;
    logic exit_ok;

    // Flags decode straight from the count register; eligibility therefore
    // always sees the pre-update occupancy.
    assign full_w   = (count_reg == CAP_VAL);
    assign empty_w  = (count_reg == '0);
    assign entry_ok = entry_req & ~full_w;
    assign exit_ok  = exit_req & ~empty_w;

    // State, timer, arbitration flag, occupancy and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg        <= IDLE;
            timer_reg        <= '0;
            prefer_entry_reg <= 1'b1;
            timed_out_reg    <= 1'b0;
            count_reg        <= '0;
            gate_open_reg    <= 1'b0;
            grant_entry_reg  <= 1'b0;
            grant_exit_reg   <= 1'b0;
            deny_reg         <= 1'b0;
            timeout_reg      <= 1'b0;
        end else begin
            state_reg        <= state_next;
            timer_reg        <= timer_next;
            prefer_entry_reg <= prefer_entry_next;
            timed_out_reg    <= timed_out_next;
            count_reg        <= count_next;
            gate_open_reg    <= gate_open_next;
            grant_entry_reg  <= grant_entry_next;
            grant_exit_reg   <= grant_exit_next;
            deny_reg         <= deny_next;
            timeout_reg      <= timeout_next;
        end
    end

    // Next-state, timer, round-robin and output decode.
    always_comb begin
        state_next        = state_reg;
        timer_next        = timer_reg;
        prefer_entry_next = prefer_entry_reg;
        timed_out_next    = timed_out_reg;
        gate_open_next    = 1'b0;
        grant_entry_next  = 1'b0;
        grant_exit_next   = 1'b0;
        deny_next         = 1'b0;
        timeout_next      = 1'b0;

        case (state_reg)
            IDLE: begin
                timed_out_next = 1'b0;
                // A full lot refuses entry every idle cycle, even when the
                // exit side is granted in the same cycle.
                deny_next = entry_req & full_w;
                if (entry_ok && (!exit_ok || prefer_entry_reg)) begin
                    state_next        = OPEN_IN;
                    timer_next        = TMR_LOAD;
                    prefer_entry_next = 1'b0;
                end else if (exit_ok) begin
                    state_next        = OPEN_OUT;
                    timer_next        = TMR_LOAD;
                    prefer_entry_next = 1'b1;
                end
            end
            OPEN_IN: begin
                gate_open_next   = 1'b1;
                grant_entry_next = 1'b1;
                timer_next       = timer_reg - TMR_ONE;
                if (car_enter) begin
                    state_next = CLOSE;
                end else if (timer_reg == TMR_ONE) begin
                    state_next     = CLOSE;
                    timed_out_next = 1'b1;
                end
            end
            OPEN_OUT: begin
                gate_open_next  = 1'b1;
                grant_exit_next = 1'b1;
                timer_next      = timer_reg - TMR_ONE;
                if (car_exit) begin
                    state_next = CLOSE;
                end else if (timer_reg == TMR_ONE) begin
                    state_next     = CLOSE;
                    timed_out_next = 1'b1;
                end
            end
            CLOSE: begin
                timeout_next = timed_out_reg;
                state_next   = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Saturating occupancy counter; simultaneous pulses cancel.
    always_comb begin
        count_next = count_reg;
        if (car_enter && !car_exit && !full_w) begin
            count_next = count_reg + CNT_W'(1);
        end else if (car_exit && !car_enter && !empty_w) begin
            count_next = count_reg - CNT_W'(1);
        end
    end

    assign gate_open   = gate_open_reg;
    assign grant_entry = grant_entry_reg;
    assign grant_exit  = grant_exit_reg;
    assign count       = count_reg;
    assign full        = full_w;
    assign empty       = empty_w;
    assign deny        = deny_reg;
    assign timeout     = timeout_reg;

endmodule

// File: tb/tb_parking_gate_controller.sv
// Bench for parking_gate_controller: a timeline model (grant edge, close edge,
// next arbitration edge) predicts every output each cycle, and directed
// scenarios add hand-computed literal expectations.
module tb_parking_gate_controller;

    localparam int CAP = 15;
    localparam int OC  = 8;

    logic       clk;
    logic       reset_n;
    logic       entry_req, exit_req, car_enter, car_exit;
    logic       gate_open, grant_entry, grant_exit, full, empty, deny, timeout;
    logic [3:0] count;

    int checks;
    int failures;

    parking_gate_controller #(
        .CAPACITY   (CAP),
        .CNT_W      (4),
        .OPEN_CYCLES(OC)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .entry_req  (entry_req),
        .exit_req   (exit_req),
        .car_enter  (car_enter),
        .car_exit   (car_exit),
        .gate_open  (gate_open),
        .grant_entry(grant_entry),
        .grant_exit (grant_exit),
        .count      (count),
        .full       (full),
        .empty      (empty),
        .deny       (deny),
        .timeout    (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cmp(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- timeline model ----------------
    int m_e, m_count, m_dir, m_grant_edge, m_next_arb, m_tmo_edge;
    bit m_prefer;
    int ex_gate, ex_ge, ex_gx, ex_deny, ex_tmo, ex_count;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_e = 0; m_count = 0; m_dir = 0; m_grant_edge = 0;
            m_next_arb = 0; m_tmo_edge = -1; m_prefer = 1'b1;
            ex_gate = 0; ex_ge = 0; ex_gx = 0; ex_deny = 0; ex_tmo = 0; ex_count = 0;
        end else begin
            int pre;
            bit en_ok, ex_ok, arb;
            m_e++;
            pre     = m_count;
            ex_deny = 0;
            ex_tmo  = (m_e == m_tmo_edge) ? 1 : 0;
            arb     = 1'b0;
            if (m_dir != 0) begin
                // gate is up from grant_edge+1 through the close edge inclusive
                ex_gate = 1;
                ex_ge   = (m_dir == 1) ? 1 : 0;
                ex_gx   = (m_dir == 2) ? 1 : 0;
                if ((m_dir == 1 && car_enter) || (m_dir == 2 && car_exit)) begin
                    m_dir = 0; m_next_arb = m_e + 2;
                end else if (m_e == m_grant_edge + OC) begin
                    m_dir = 0; m_next_arb = m_e + 2; m_tmo_edge = m_e + 1;
                end
            end else begin
                ex_gate = 0; ex_ge = 0; ex_gx = 0;
                arb = (m_e >= m_next_arb);
            end
            if (arb) begin
                ex_deny = (entry_req && pre == CAP) ? 1 : 0;
                en_ok   = entry_req && (pre != CAP);
                ex_ok   = exit_req && (pre != 0);
                if (en_ok && (!ex_ok || m_prefer)) begin
                    m_dir = 1; m_grant_edge = m_e; m_prefer = 1'b0;
                end else if (ex_ok) begin
                    m_dir = 2; m_grant_edge = m_e; m_prefer = 1'b1;
                end
            end
            if (car_enter && !car_exit && m_count < CAP) m_count++;
            else if (car_exit && !car_enter && m_count > 0) m_count--;
            ex_count = m_count;
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (reset_n) begin
            cmp("m_gate_open", int'(gate_open), ex_gate);
            cmp("m_grant_entry", int'(grant_entry), ex_ge);
            cmp("m_grant_exit", int'(grant_exit), ex_gx);
            cmp("m_deny", int'(deny), ex_deny);
            cmp("m_timeout", int'(timeout), ex_tmo);
            cmp("m_count", int'(count), ex_count);
            cmp("m_full", int'(full), (ex_count == CAP) ? 1 : 0);
            cmp("m_empty", int'(empty), (ex_count == 0) ? 1 : 0);
        end
    end

    // Bounded wait for gate_open to reach a level; expiry is a failure.
    task automatic wait_gate(input logic want, input string name);
        int n;
        n = 0;
        while (gate_open !== want && n < 40) begin
            @(negedge clk);
            n++;
        end
        cmp(name, int'(gate_open), int'(want));
    endtask

    int seq[4];
    int open_len;

    initial begin
        checks = 0; failures = 0;
        reset_n = 1'b0;
        entry_req = 1'b0; exit_req = 1'b0; car_enter = 1'b0; car_exit = 1'b0;
        repeat (3) @(negedge clk);
        cmp("rst_gate", int'(gate_open), 0);
        cmp("rst_count", int'(count), 0);
        cmp("rst_empty", int'(empty), 1);
        cmp("rst_full", int'(full), 0);
        cmp("rst_deny", int'(deny), 0);
        reset_n = 1'b1;
        @(negedge clk);

        // entry then exit on an empty lot
        entry_req = 1'b1;
        @(negedge clk);
        entry_req = 1'b0;
        cmp("grant_not_yet", int'(gate_open), 0);
        @(negedge clk);
        cmp("grant_gate", int'(gate_open), 1);
        cmp("grant_entry", int'(grant_entry), 1);
        cmp("grant_exit_low", int'(grant_exit), 0);
        car_enter = 1'b1;
        @(negedge clk);
        car_enter = 1'b0;
        cmp("count_one", int'(count), 1);
        cmp("gate_still_up", int'(gate_open), 1);
        @(negedge clk);
        cmp("gate_closed", int'(gate_open), 0);
        repeat (2) @(negedge clk);
        exit_req = 1'b1;
        wait_gate(1'b1, "exit_open_wait");
        exit_req = 1'b0;
        cmp("exit_granted", int'(grant_exit), 1);
        car_exit = 1'b1;
        @(negedge clk);
        car_exit = 1'b0;
        cmp("count_zero", int'(count), 0);
        cmp("empty_again", int'(empty), 1);
        wait_gate(1'b0, "exit_close_wait");
        @(negedge clk);

        // fill the lot
        for (int k = 0; k < CAP; k++) begin
            entry_req = 1'b1;
            wait_gate(1'b1, "fill_open_wait");
            entry_req = 1'b0;
            car_enter = 1'b1;
            @(negedge clk);
            car_enter = 1'b0;
            wait_gate(1'b0, "fill_close_wait");
            @(negedge clk);
        end
        cmp("fill_count", int'(count), 15);
        cmp("fill_full", int'(full), 1);
        entry_req = 1'b1;
        @(negedge clk);
        cmp("deny_1", int'(deny), 1);
        cmp("deny_no_gate", int'(gate_open), 0);
        @(negedge clk);
        cmp("deny_2", int'(deny), 1);
        exit_req = 1'b1;
        @(negedge clk);
        cmp("deny_with_exit", int'(deny), 1);
        entry_req = 1'b0; exit_req = 1'b0;
        @(negedge clk);
        cmp("full_exit_gate", int'(gate_open), 1);
        cmp("full_exit_grant", int'(grant_exit), 1);
        cmp("deny_stops", int'(deny), 0);
        car_exit = 1'b1;
        @(negedge clk);
        car_exit = 1'b0;
        wait_gate(1'b0, "full_exit_close");
        repeat (2) @(negedge clk);
        cmp("count_14", int'(count), 14);
        car_enter = 1'b1;
        @(negedge clk);
        car_enter = 1'b0;
        cmp("count_15", int'(count), 15);
        car_enter = 1'b1;
        @(negedge clk);
        car_enter = 1'b0;
        cmp("sat_high", int'(count), 15);
        car_exit = 1'b1;
        repeat (10) @(negedge clk);
        car_exit = 1'b0;
        cmp("count_5", int'(count), 5);

        // both requests held: round-robin
        entry_req = 1'b1; exit_req = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_gate(1'b1, "alt_open_wait");
            seq[k] = grant_entry ? 1 : 2;
            if (grant_entry) car_enter = 1'b1;
            else car_exit = 1'b1;
            @(negedge clk);
            car_enter = 1'b0; car_exit = 1'b0;
            wait_gate(1'b0, "alt_close_wait");
        end
        entry_req = 1'b0; exit_req = 1'b0;
        cmp("alt_0_entry", seq[0], 1);
        cmp("alt_1_exit", seq[1], 2);
        cmp("alt_2_entry", seq[2], 1);
        cmp("alt_3_exit", seq[3], 2);
        repeat (2) @(negedge clk);

        // entry granted, no car: timeout
        entry_req = 1'b1;
        wait_gate(1'b1, "tmo_open_wait");
        entry_req = 1'b0;
        open_len = 0;
        while (gate_open && open_len < 20) begin
            open_len++;
            @(negedge clk);
        end
        cmp("tmo_open_len", open_len, 8);
        cmp("tmo_pulse", int'(timeout), 1);
        cmp("tmo_count", int'(count), 5);
        @(negedge clk);
        cmp("tmo_one_shot", int'(timeout), 0);

        // counter corner cases
        car_enter = 1'b1; car_exit = 1'b1;
        @(negedge clk);
        car_enter = 1'b0; car_exit = 1'b0;
        cmp("both_pulses", int'(count), 5);
        car_exit = 1'b1;
        repeat (5) @(negedge clk);
        car_exit = 1'b0;
        cmp("drain_0", int'(count), 0);
        car_exit = 1'b1;
        @(negedge clk);
        car_exit = 1'b0;
        cmp("sat_low", int'(count), 0);

        // reset while serving the exit side at count 7
        car_enter = 1'b1;
        repeat (7) @(negedge clk);
        car_enter = 1'b0;
        cmp("count_7", int'(count), 7);
        exit_req = 1'b1;
        wait_gate(1'b1, "rst_exit_wait");
        cmp("rst_in_open_out", int'(grant_exit), 1);
        #2;
        reset_n = 1'b0;
        #1;
        cmp("async_gate", int'(gate_open), 0);
        cmp("async_grant_exit", int'(grant_exit), 0);
        cmp("async_count", int'(count), 0);
        cmp("async_empty", int'(empty), 1);
        exit_req = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        entry_req = 1'b1;
        @(negedge clk);
        entry_req = 1'b0;
        @(negedge clk);
        cmp("post_rst_gate", int'(gate_open), 1);
        cmp("post_rst_entry", int'(grant_entry), 1);
        car_enter = 1'b1;
        @(negedge clk);
        car_enter = 1'b0;
        repeat (4) @(negedge clk);
        cmp("post_rst_count", int'(count), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
